serial_add_ctrl: RTL
====================

# serial_add_ctrl

Bit-serial adder controller that time-shares a single 1-bit full-adder cell to add two WIDTH-bit operands plus a carry-in, one bit per clock, LSB first. It sequences operand bits into the cell, holds the running carry, and assembles the result in a shift register. It sits between an operand producer and a result consumer, both connected through valid/ready handshakes. Area is traded for latency: one adder cell serves the whole word.

## Interface
- WIDTH, default 8: operand and result width in bits; must be ≥ 2.
- clk  in  1  sole clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset; release is synchronised externally.
- in_valid  in  1  operand word valid.
- in_ready  out  1  controller can accept an operand word.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- ci  in  1  carry-in for bit 0.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result word.
- co  out  1  carry-out of bit WIDTH-1.
- busy  out  1  high in RUN or DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: capture a, b, ci into internal registers; clear bit counter; go to RUN.
- RUN (one cycle per bit i = 0..WIDTH-1):
  - Cell inputs are a_reg[i], b_reg[i], carry_reg.
  - Cell sum bit shifts into the MSB of sum_reg while sum_reg shifts right.
  - carry_reg takes the cell carry.
  - Counter increments.
  - When the counter reaches WIDTH-1, the edge that completes bit WIDTH-1 moves the FSM to DONE.
- DONE:
  - out_valid=1; sum=sum_reg; co=carry_reg.
  - sum and co are held stable until out_valid && out_ready, then the FSM returns to IDLE.
- in_ready=0 in RUN and DONE. in_valid during those states is ignored and has no side effects.
- Arithmetic: {co,sum} = a + b + ci, evaluated over WIDTH+1 bits with no truncation error. Overflow is reported only via co.
- Bit counter width: $clog2(WIDTH). It must not wrap before bit WIDTH-1 completes.
- sum and co are registered outputs. Outside DONE they keep their last value; they are not cleared.

## Timing
- Reset values: state=IDLE; in_ready=1 (from the first cycle after reset release); out_valid=0; busy=0; sum=0; co=0; counter=0; carry_reg=0.
- Latency: accept on edge E0. Bits 0..WIDTH-1 compute on edges E1..E_WIDTH. out_valid is high in the cycle after E_WIDTH, i.e. WIDTH cycles after acceptance.
- Throughput with out_ready tied high: one result every WIDTH+2 cycles (accept, WIDTH compute edges, handshake, return to IDLE).
- out_ready high in the first DONE cycle completes the handshake on that edge. The next operand can be accepted one cycle later.
- Reset asserted mid-RUN or mid-DONE: immediate return to the reset state; the partial result is discarded; no out_valid pulse.
- An in_valid pulse shorter than one cycle outside IDLE is lost. The producer must hold in_valid until in_ready.

## Structure
- Package serial_add_pkg: state enum typedef (IDLE, RUN, DONE) and the WIDTH default constant.
- Sub-module fa_bit: purely combinational 1-bit full adder (a, b, ci -> s, co). Exactly one instance.
- The top level holds the FSM, operand registers, carry register, counter, and sum shift register.

## Test plan
- WIDTH=8, a=0x5A, b=0xA5, ci=1 -> sum=0x00, co=1; out_valid first high 8 cycles after acceptance.
- a=0xFF, b=0x01, ci=0 -> sum=0x00, co=1. Then a=0x12, b=0x34, ci=0 back-to-back -> sum=0x46, co=0; spacing between results is 10 cycles.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid, sum and co stay stable; in_ready stays 0; a new in_valid is ignored.
- Reset mid-RUN (after bit 3): all outputs return to reset values; a following a=0x0F, b=0x01, ci=0 gives sum=0x10, co=0.
- Operands change while busy: alter a and b during RUN -> the result reflects the values captured at acceptance.
- WIDTH=2 build: a=3, b=3, ci=1 -> sum=3, co=1; latency 2 cycles.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
package serial_add_pkg;

  // Default operand and result width
  localparam int WIDTH_DEF = 8;

  // Controller sequencing states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_add_ctrl_fa_bit.sv
// Single 1-bit full-adder cell, time-shared across every bit of the word.
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  // Sum and carry of one bit position
  always_comb begin
    s  = a ^ b ^ ci;
    co = (a & b) | (a & ci) | (b & ci);
  end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell computes a + b + ci over WIDTH
// cycles, LSB first, between valid/ready producer and consumer.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  // Bit inserted at the top of the partial-sum register
  localparam logic [WIDTH-2:0] TOP1 = (WIDTH-1)'(1) << (WIDTH - 2);

  state_t           state;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic             carry_reg;
  logic [CW-1:0]    cnt;
  // Low WIDTH-1 result bits; the final bit comes straight from the cell
  // on the completing edge, so the full-width shift never needs storing.
  logic [WIDTH-2:0] sum_reg;
  logic             cell_s, cell_co;

  fa_bit u_fa (
    .a  (a_reg[cnt]),
    .b  (b_reg[cnt]),
    .ci (carry_reg),
    .s  (cell_s),
    .co (cell_co)
  );

  // Sequencer: accept operands, step one bit per cycle, hold result until taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      sum       <= '0;
      co        <= 1'b0;
      cnt       <= '0;
      carry_reg <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= a;
            b_reg     <= b;
            carry_reg <= ci;
            cnt       <= '0;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          sum_reg   <= (sum_reg >> 1) | (cell_s ? TOP1 : '0);
          carry_reg <= cell_co;
          cnt       <= cnt + CW'(1);
          if (cnt == LAST) begin
            sum       <= {cell_s, sum_reg};
            co        <= cell_co;
            cnt       <= '0;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
